// File: rtl/sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd1) return 32'd1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// One-bit full-subtractor cell: d = x - y - bi, with borrow out.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first,
// with valid/ready handshakes on operands and result.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, a_sr_d;
  logic [WIDTH-1:0] b_sr, b_sr_d;
  logic [WIDTH-1:0] res_sr, res_sr_d;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_ff, borrow_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             bout_d, zero_d, ovf_d;
  logic             in_ready_d, out_valid_d;

  logic [DIGIT-1:0] dd;
  logic [DIGIT:0]   bc;

  // Borrow chain across the digit; bc[DIGIT-1] is the borrow into the digit's MSB.
  assign bc[0] = borrow_ff;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    fs_cell u_cell (
      .x  (a_sr[i]),
      .y  (b_sr[i]),
      .bi (bc[i]),
      .d  (dd[i]),
      .bo (bc[i+1])
    );
  end

  // New digit enters at the top so the LSB digit ends at bit 0 after STEPS shifts.
  assign res_shift = (res_sr >> DIGIT) | (WIDTH'(dd) << (WIDTH - DIGIT));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr;
    b_sr_d   = b_sr;
    res_sr_d = res_sr;
    borrow_d = borrow_ff;
    cnt_d    = cnt;
    diff_d   = diff;
    bout_d   = bout;
    zero_d   = zero;
    ovf_d    = ovf;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr >> DIGIT;
        b_sr_d   = b_sr >> DIGIT;
        res_sr_d = res_shift;
        borrow_d = bc[DIGIT];
        cnt_d    = cnt + CW'(1);
        if (cnt == LAST) begin
          diff_d  = res_shift;
          bout_d  = bc[DIGIT];
          zero_d  = (res_shift == '0);
          ovf_d   = bc[DIGIT] ^ bc[DIGIT-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      borrow_ff <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr      <= a_sr_d;
      b_sr      <= b_sr_d;
      res_sr    <= res_sr_d;
      borrow_ff <= borrow_d;
      cnt       <= cnt_d;
      diff      <= diff_d;
      bout      <= bout_d;
      zero      <= zero_d;
      ovf       <= ovf_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: three configurations (8/1, 8/4, 4/2)
// checked against an arithmetic reference model.
module tb_serial_subtractor;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       z;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ta, tbv;
  logic       tbin;
  logic [2:0] iv, ir, ov, ory, bo, zr, vf;
  logic [7:0] d0, d1;
  logic [3:0] d2;

  int checks = 0;
  int errors = 0;
  int wid[3] = '{8, 8, 4};
  int stp[3] = '{8, 2, 2};

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(ta), .b(tbv), .bin(tbin),
    .out_valid(ov[0]), .out_ready(ory[0]), .diff(d0), .bout(bo[0]), .zero(zr[0]), .ovf(vf[0])
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(ta), .b(tbv), .bin(tbin),
    .out_valid(ov[1]), .out_ready(ory[1]), .diff(d1), .bout(bo[1]), .zero(zr[1]), .ovf(vf[1])
  );

  serial_subtractor #(.WIDTH(4), .DIGIT(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(ta[3:0]), .b(tbv[3:0]), .bin(tbin),
    .out_valid(ov[2]), .out_ready(ory[2]), .diff(d2), .bout(bo[2]), .zero(zr[2]), .ovf(vf[2])
  );

  // Reference: plain integer arithmetic, unsigned for diff/borrow, signed for overflow.
  function automatic exp_t model(input int w, input logic [7:0] av, input logic [7:0] bv,
                                 input logic bn);
    exp_t e;
    int mask, half, ai, bi, full, sa, sb, sd;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ai   = int'(av) & mask;
    bi   = int'(bv) & mask;
    full = ai - bi - int'(bn);
    sa   = (ai >= half) ? ai - (1 << w) : ai;
    sb   = (bi >= half) ? bi - (1 << w) : bi;
    sd   = sa - sb - int'(bn);
    e.d  = 8'(full & mask);
    e.bo = (full < 0);
    e.z  = ((full & mask) == 0);
    e.v  = (sd < -half) || (sd > half - 1);
    return e;
  endfunction

  function automatic logic [7:0] dout(input int k);
    case (k)
      0:       return d0;
      1:       return d1;
      default: return {4'h0, d2};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic issue(input int k, input logic [7:0] av, input logic [7:0] bv,
                       input logic bn, input bit lat);
    int   n;
    exp_t e;
    n = 0;
    while (!ir[k] && n < 100) begin @(posedge clk); #1; n++; end
    if (!ir[k]) begin
      checks++;
      errors++;
      $display("FAIL u%0d in_ready timeout: got 0 expected 1", k);
      return;
    end
    ta = av; tbv = bv; tbin = bn; iv[k] = 1'b1;
    e = model(wid[k], av, bv, bn);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(posedge clk); #1;
    iv[k] = 1'b0;
    if (lat) begin
      n = 0;
      while (!ov[k] && n < 100) begin @(posedge clk); #1; n++; end
      chk($sformatf("u%0d latency", k), 32'(n), 32'(stp[k]));
    end
  endtask

  // Monitor: each negedge with out_valid && out_ready precedes exactly one handshake edge.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   have;
    for (int k = 0; k < 3; k++) begin
      if (rst === 1'b0 && ov[k] && ory[k]) begin
        have = 1'b1;
        case (k)
          0:       if (q0.size() == 0) have = 1'b0; else e = q0.pop_front();
          1:       if (q1.size() == 0) have = 1'b0; else e = q1.pop_front();
          default: if (q2.size() == 0) have = 1'b0; else e = q2.pop_front();
        endcase
        if (!have) begin
          checks++;
          errors++;
          $display("FAIL u%0d unexpected result: got diff %0h expected none", k, dout(k));
        end else begin
          chk($sformatf("u%0d diff", k), 32'(dout(k)), 32'(e.d));
          chk($sformatf("u%0d bout", k), 32'(bo[k]), 32'(e.bo));
          chk($sformatf("u%0d zero", k), 32'(zr[k]), 32'(e.z));
          chk($sformatf("u%0d ovf", k), 32'(vf[k]), 32'(e.v));
        end
      end
    end
  end

  initial begin : stim
    exp_t e;
    int   n;
    rst = 1'b1; iv = '0; ory = 3'b111; ta = '0; tbv = '0; tbin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d reset in_ready", k), 32'(ir[k]), 32'd1);
      chk($sformatf("u%0d reset out_valid", k), 32'(ov[k]), 32'd0);
      chk($sformatf("u%0d reset diff", k), 32'(dout(k)), 32'd0);
      chk($sformatf("u%0d reset flags", k), 32'({bo[k], zr[k], vf[k]}), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    issue(0, 8'h5A, 8'h3C, 1'b0, 1'b1);
    issue(0, 8'h00, 8'h01, 1'b0, 1'b1);
    issue(0, 8'h80, 8'h00, 1'b1, 1'b1);
    issue(1, 8'h33, 8'h33, 1'b0, 1'b1);
    issue(1, 8'h7F, 8'hFF, 1'b1, 1'b1);

    // Random operands on both 8-bit configurations
    for (int i = 0; i < 30; i++) begin
      issue(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      issue(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    // Backpressure with stray in_valid during RUN and DONE
    ory[0] = 1'b0;
    e = model(8, 8'h12, 8'h34, 1'b1);
    issue(0, 8'h12, 8'h34, 1'b1, 1'b0);
    ta = 8'hFF; tbv = 8'h00; tbin = 1'b0; iv[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp run in_ready", 32'(ir[0]), 32'd0);
      chk("bp run out_valid", 32'(ov[0]), 32'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp done out_valid", 32'(ov[0]), 32'd1);
      chk("bp done in_ready", 32'(ir[0]), 32'd0);
      chk("bp done diff", 32'(d0), 32'(e.d));
      chk("bp done flags", 32'({bo[0], zr[0], vf[0]}), 32'({e.bo, e.z, e.v}));
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    ory[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready", 32'(ir[0]), 32'd1);
    chk("bp release out_valid", 32'(ov[0]), 32'd0);

    // Reset on the third RUN edge discards the partial result
    issue(0, 8'hAB, 8'h11, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    chk("midrst in_ready", 32'(ir[0]), 32'd1);
    chk("midrst out_valid", 32'(ov[0]), 32'd0);
    chk("midrst diff", 32'(d0), 32'd0);
    chk("midrst bout", 32'(bo[0]), 32'd0);
    issue(0, 8'h10, 8'h20, 1'b0, 1'b1);

    // Exhaustive 4-bit sweep
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int bn = 0; bn < 2; bn++)
          issue(2, 8'(av), 8'(bv), 1'(bn), 1'b1);

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", q0.size() + q1.size() + q2.size());
    end
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
